sort_stream_host: RTL

- Host-side initiator for the parallel start/done sort engine.
- Collects N words from an upstream valid/ready stream into a frame register and drives the engine's parallel data input.
- Issues a one-cycle start, waits for done with a watchdog, captures the parallel sorted result, then streams it downstream word by word with a last marker.
- Sits between the serial datapath and the sort engine; the engine itself is unmodified.

---
 rtl/sort_stream_host.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sort_stream_host.sv
// sort_stream_host: host-side initiator for a parallel start/done sort engine.
// Gathers N words from an upstream valid/ready stream, fires a one-cycle
// start, waits for done under a watchdog, then replays the sorted frame
// downstream one word at a time with a last marker. One frame in flight.
module sort_stream_host #(
   parameter int N       = 6,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             sort_start,
   output logic [WIDTH-1:0] sort_data [N],
   input  logic             sort_done,
   input  logic [WIDTH-1:0] sort_result [N],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             error
);

   localparam int CNT_W = $clog2(N);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic [WIDTH-1:0] frame_q [N];
   logic [WIDTH-1:0] frame_d [N];
   logic [WIDTH-1:0] result_q [N];
   logic [WIDTH-1:0] result_d [N];

   // The engine sees the frame register directly; it only changes in LOAD.
   assign sort_data = frame_q;

   // State, counters, frame and result registers with async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         load_cnt_q  <= '0;
         drain_cnt_q <= '0;
         wdog_q      <= '0;
         frame_q     <= '{default: '0};
         result_q    <= '{default: '0};
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         wdog_q      <= wdog_d;
         frame_q     <= frame_d;
         result_q    <= result_d;
      end
   end

   // Next-state logic and outputs; everything decoded from the current state.
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      drain_cnt_d = drain_cnt_q;
      wdog_d      = wdog_q;
      frame_d     = frame_q;
      result_d    = result_q;
      in_ready    = 1'b0;
      sort_start  = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      busy        = 1'b1;
      error       = 1'b0;

      case (state_q)
         ST_LOAD: begin
            busy     = 1'b0;
            in_ready = rst_n;
            if (in_valid) begin
               frame_d[load_cnt_q] = in_data;
               if (load_cnt_q == LAST_IDX) begin
                  load_cnt_d = '0;
                  state_d    = ST_START;
               end else begin
                  load_cnt_d = load_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_START: begin
            sort_start = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (sort_done) begin
               result_d = sort_result;
               wdog_d   = '0;
               state_d  = ST_DRAIN;
            end else if (wdog_q == WD_MAX) begin
               error   = 1'b1;
               wdog_d  = '0;
               state_d = ST_LOAD;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            out_data  = result_q[drain_cnt_q];
            out_last  = (drain_cnt_q == LAST_IDX);
            if (out_ready) begin
               if (drain_cnt_q == LAST_IDX) begin
                  drain_cnt_d = '0;
                  state_d     = ST_LOAD;
               end else begin
                  drain_cnt_d = drain_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

endmodule
